bsg_dramsim3_traffic_master: RTL and testbench
==============================================

# bsg_dramsim3_traffic_master

Sequencing controller between a trace-driven command FIFO and a single `bsg_nonsynth_dramsim3` channel port in the DRAM bandwidth testbench. It pops read/write commands and issues them on the DRAM command handshake, supplying write data for each write. It bounds in-flight reads with a credit counter, drains outstanding reads after the trace ends, and reports read, write and elapsed-cycle counts for bandwidth computation.

## Interface
- `channel_addr_width_p`, 29: DRAM channel address width.
- `data_width_p`, 512: DRAM data beat width; must be ≥ `channel_addr_width_p`.
- `max_reads_p`, 16: maximum outstanding reads; must be ≥ 1.
- `count_width_p`, 32: width of the statistics counters.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous assert, active-low.
- `start_i` in 1: level; a high sample in IDLE begins the run.
- `cmd_v_i` in 1: a command is available.
- `cmd_write_not_read_i` in 1: 1 = write, 0 = read.
- `cmd_addr_i` in `channel_addr_width_p`: command address.
- `cmd_yumi_o` out 1: command consumed.
- `cmd_done_i` in 1: the trace source has no more commands.
- `v_o`, `write_not_read_o`, `ch_addr_o` out 1/1/`channel_addr_width_p`: DRAM command.
- `yumi_i` in 1: DRAM accepted the command.
- `data_v_o` out 1, `data_o` out `data_width_p`: write data.
- `data_yumi_i` in 1: DRAM accepted the write data.
- `data_v_i` in 1: read data return. Data content is ignored.
- `done_o` out 1: run complete (sticky until reset).
- `error_o` out 1: sticky protocol error.
- `read_count_o`, `write_count_o`, `cycle_count_o` out `count_width_p` each: statistics.

## Operation
- FSM states: IDLE, FETCH, CMD, WDATA, DRAIN, DONE.
- IDLE: all valids low. `start_i`=1 → FETCH.
- FETCH: holds nothing. A command is popped when `cmd_v_i`=1 and the read-credit condition holds.
  - Read-credit condition: the command is a write, or outstanding < `max_reads_p`.
  - On pop: `cmd_yumi_o`=1 combinationally, the command is latched into a register, and the FSM goes → CMD.
  - `cmd_v_i`=0 and `cmd_done_i`=1 → DRAIN.
- CMD: `v_o`=1 with the latched command, held stable until `yumi_i`.
  - On `yumi_i` for a read: outstanding increments, `read_count_o` increments, → FETCH.
  - On `yumi_i` for a write: → WDATA.
- WDATA: `data_v_o`=1. `data_o` = zero-extended latched address.
  - On `data_yumi_i`: `write_count_o` increments, → FETCH.
- DRAIN: outstanding == 0 → DONE.
- DONE: `done_o`=1. The FSM stays here until reset; `start_i` is ignored.
- `data_v_i` decrements the outstanding count in any state.
  - An increment and a decrement in the same cycle leave the count unchanged.
  - `data_v_i` with outstanding == 0 sets `error_o`; the count stays at 0 (no wrap).
- `cycle_count_o` increments every cycle in FETCH, CMD, WDATA and DRAIN.
- All counters saturate at all-ones.
- `yumi_i` or `data_yumi_i` arriving while the matching valid is low sets `error_o` and is otherwise ignored.

## Timing
- Reset (async, `reset_n_i`=0): FSM → IDLE; all counters, the outstanding count, `done_o` and `error_o` → 0; all outputs low.
- `cmd_yumi_o`, `v_o` and `data_v_o` are never high in the same cycle.
- Minimum read issue rate: 1 command per 2 cycles (FETCH, CMD with `yumi_i` in its first cycle).
- Minimum write issue rate: 1 command per 3 cycles.
- Start latency: `start_i` sampled high in IDLE; FETCH in the next cycle; earliest `v_o` two cycles after the start sample.
- Credit check uses the registered outstanding value. A decrement in the same cycle does not enable the pop until the next cycle.
- DONE is entered in the cycle after outstanding reaches 0 in DRAIN.
- If reset asserts mid-run, in-flight DRAM reads may return after reset. Each such return raises `error_o`; the bench keeps the DUT in reset until returns drain.

## Structure
- Shared package `bsg_dramsim3_traffic_pkg`:
  - state enum `traffic_state_e`;
  - command struct `{write_not_read, addr}`.
- Sub-module `bsg_dramsim3_read_credit_counter`:
  - up/down counter with full, empty and underflow flags;
  - parameterized by `max_reads_p`.
- Counters: `bsg_counter_clear_up`-style with a saturation guard.

## Test plan
- 4 reads, `max_reads_p`=2, returns withheld:
  - exactly 2 `v_o` accepts, then stall with `cmd_yumi_o`=0;
  - 1 `data_v_i` → third read issues;
  - end: `read_count_o`=4, `done_o`=1.
- 3 writes to addresses 0x10, 0x20, 0x30 with `yumi_i`/`data_yumi_i` delayed 2 cycles each:
  - `data_o` = 0x10, 0x20, 0x30 in order;
  - `write_count_o`=3;
  - `ch_addr_o` held stable during stalls.
- Interleaved W, R, W, R with `cmd_done_i` asserted while reads are outstanding:
  - FSM remains in DRAIN until both returns;
  - `done_o` rises the cycle after the last return.
- `data_v_i` in IDLE with outstanding 0 → `error_o`=1, outstanding stays 0.
- Simultaneous read accept and `data_v_i` return at outstanding=1 → outstanding stays 1.
- Async reset asserted mid-WDATA:
  - all outputs 0 immediately;
  - after release and `start_i`, a fresh run completes with counts starting from 0.

Source files
------------

// File: rtl/bsg_dramsim3_traffic_pkg.sv
// Shared types for the DRAMSim3 traffic master.
//   traffic_state_e : sequencing FSM states
//   traffic_cmd_t   : latched trace command {write_not_read, addr}
//   state_is_active : states that count toward elapsed run cycles
package bsg_dramsim3_traffic_pkg;

  // The command register is sized for the widest supported channel address;
  // the top zero-extends narrower addresses into it.
  localparam int unsigned MaxAddrWidth = 64;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCmd,
    StWdata,
    StDrain,
    StDone
  } traffic_state_e;

  typedef struct packed {
    logic                    write_not_read;
    logic [MaxAddrWidth-1:0] addr;
  } traffic_cmd_t;

  function automatic logic state_is_active(traffic_state_e s);
    return (s == StFetch) || (s == StCmd) || (s == StWdata) || (s == StDrain);
  endfunction

endpackage

// File: rtl/bsg_dramsim3_read_credit_counter.sv
// Outstanding-read counter bounding in-flight DRAM reads.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   up_i             : a read was accepted by DRAM
//   down_i           : a read returned
//   count_o          : registered outstanding count
//   full_o           : count == max_reads_p
//   empty_o          : count == 0
//   underflow_o      : return seen with nothing outstanding (count holds at 0)
module bsg_dramsim3_read_credit_counter #(
  parameter int unsigned max_reads_p = 16,
  localparam int unsigned CountW = $clog2(max_reads_p + 1)
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              up_i,
  input  logic              down_i,
  output logic [CountW-1:0] count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              underflow_o
);

  logic [CountW-1:0] count_q, count_d;
  logic              inc, dec;

  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CountW'(max_reads_p));
  assign underflow_o = down_i & empty_o;

  always_comb begin
    count_d = count_q;
    // At full a simultaneous return makes room, so the pair nets to no change.
    inc = up_i & (~full_o | down_i);
    dec = down_i & ~empty_o;
    if (inc && !dec) begin
      count_d = count_q + CountW'(1);
    end else if (dec && !inc) begin
      count_d = count_q - CountW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bsg_dramsim3_traffic_master.sv
// Sequencing controller between a trace command FIFO and one DRAMSim3 channel.
// Pops commands, issues them on the DRAM command handshake, supplies write
// data (zero-extended address), bounds outstanding reads, drains after the
// trace ends and keeps read/write/elapsed-cycle statistics.
// Ports:
//   clk_i, reset_n_i             : clock, async active-low reset
//   start_i                      : level, starts the run from IDLE
//   cmd_v_i/cmd_write_not_read_i/cmd_addr_i/cmd_yumi_o : trace command pop
//   cmd_done_i                   : trace exhausted
//   v_o/write_not_read_o/ch_addr_o/yumi_i : DRAM command handshake
//   data_v_o/data_o/data_yumi_i  : DRAM write data handshake
//   data_v_i                     : DRAM read return (content ignored)
//   done_o, error_o              : run complete, sticky protocol error
//   read_count_o/write_count_o/cycle_count_o : saturating statistics
module bsg_dramsim3_traffic_master
  import bsg_dramsim3_traffic_pkg::*;
#(
  parameter int unsigned channel_addr_width_p = 29,
  parameter int unsigned data_width_p         = 512,
  parameter int unsigned max_reads_p          = 16,
  parameter int unsigned count_width_p        = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            start_i,
  input  logic                            cmd_v_i,
  input  logic                            cmd_write_not_read_i,
  input  logic [channel_addr_width_p-1:0] cmd_addr_i,
  output logic                            cmd_yumi_o,
  input  logic                            cmd_done_i,
  output logic                            v_o,
  output logic                            write_not_read_o,
  output logic [channel_addr_width_p-1:0] ch_addr_o,
  input  logic                            yumi_i,
  output logic                            data_v_o,
  output logic [data_width_p-1:0]         data_o,
  input  logic                            data_yumi_i,
  input  logic                            data_v_i,
  output logic                            done_o,
  output logic                            error_o,
  output logic [count_width_p-1:0]        read_count_o,
  output logic [count_width_p-1:0]        write_count_o,
  output logic [count_width_p-1:0]        cycle_count_o
);

  localparam int unsigned CreditW = $clog2(max_reads_p + 1);

  traffic_state_e state_q, state_d;
  traffic_cmd_t   cmd_q, cmd_d;
  logic           error_q, error_d;

  logic [count_width_p-1:0] read_count_q, write_count_q, cycle_count_q;

  logic               read_accept, write_done, drain_clear;
  logic [CreditW-1:0] credit_count;
  logic               credit_full, credit_empty, credit_underflow;

  bsg_dramsim3_read_credit_counter #(
    .max_reads_p(max_reads_p)
  ) u_credit (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .up_i       (read_accept),
    .down_i     (data_v_i),
    .count_o    (credit_count),
    .full_o     (credit_full),
    .empty_o    (credit_empty),
    .underflow_o(credit_underflow)
  );

  // Leave DRAIN as soon as the count is, or is about to become, zero so that
  // DONE follows the last return by one cycle.
  assign drain_clear = credit_empty || ((credit_count == CreditW'(1)) && data_v_i);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_yumi_o  = 1'b0;
    read_accept = 1'b0;
    write_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        if (cmd_v_i) begin
          // Credit check is on the registered count only.
          if (cmd_write_not_read_i || !credit_full) begin
            cmd_yumi_o           = 1'b1;
            cmd_d.write_not_read = cmd_write_not_read_i;
            cmd_d.addr           = '0;
            cmd_d.addr[channel_addr_width_p-1:0] = cmd_addr_i;
            state_d              = StCmd;
          end
        end else if (cmd_done_i) begin
          state_d = StDrain;
        end
      end
      StCmd: begin
        if (yumi_i) begin
          if (cmd_q.write_not_read) begin
            state_d = StWdata;
          end else begin
            read_accept = 1'b1;
            state_d     = StFetch;
          end
        end
      end
      StWdata: begin
        if (data_yumi_i) begin
          write_done = 1'b1;
          state_d    = StFetch;
        end
      end
      StDrain: begin
        if (drain_clear) state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign v_o              = (state_q == StCmd);
  assign data_v_o         = (state_q == StWdata);
  assign done_o           = (state_q == StDone);
  assign write_not_read_o = cmd_q.write_not_read;
  assign ch_addr_o        = cmd_q.addr[channel_addr_width_p-1:0];
  assign error_o          = error_q;
  assign read_count_o     = read_count_q;
  assign write_count_o    = write_count_q;
  assign cycle_count_o    = cycle_count_q;

  always_comb begin
    data_o = '0;
    data_o[channel_addr_width_p-1:0] = cmd_q.addr[channel_addr_width_p-1:0];
  end

  // Handshake acks with no matching valid are flagged and otherwise ignored.
  assign error_d = error_q | credit_underflow | (yumi_i & ~v_o) | (data_yumi_i & ~data_v_o);

  // Upper command-address bits exist only for the widest configuration.
  logic unused_cmd_addr;
  assign unused_cmd_addr = ^cmd_q.addr;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= StIdle;
      cmd_q         <= '0;
      error_q       <= 1'b0;
      read_count_q  <= '0;
      write_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      error_q <= error_d;
      if (read_accept && (read_count_q != '1)) begin
        read_count_q <= read_count_q + count_width_p'(1);
      end
      if (write_done && (write_count_q != '1)) begin
        write_count_q <= write_count_q + count_width_p'(1);
      end
      if (state_is_active(state_q) && (cycle_count_q != '1)) begin
        cycle_count_q <= cycle_count_q + count_width_p'(1);
      end
    end
  end

endmodule

// File: tb/tb_bsg_dramsim3_traffic_master.sv
// Directed self-checking bench for bsg_dramsim3_traffic_master.
module tb_bsg_dramsim3_traffic_master;
  import bsg_dramsim3_traffic_pkg::*;

  localparam int unsigned AW = 29;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic          cmd_v_i = 1'b0;
  logic          cmd_write_not_read_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic          cmd_yumi_o;
  logic          cmd_done_i = 1'b0;
  logic          v_o, write_not_read_o;
  logic [AW-1:0] ch_addr_o;
  logic          yumi_i = 1'b0;
  logic          data_v_o;
  logic [DW-1:0] data_o;
  logic          data_yumi_i = 1'b0;
  logic          data_v_i = 1'b0;
  logic          done_o, error_o;
  logic [CW-1:0] read_count_o, write_count_o, cycle_count_o;

  always #5 clk = ~clk;

  bsg_dramsim3_traffic_master #(
    .channel_addr_width_p(AW),
    .data_width_p        (DW),
    .max_reads_p         (2),
    .count_width_p       (CW)
  ) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n_i),
    .start_i             (start_i),
    .cmd_v_i             (cmd_v_i),
    .cmd_write_not_read_i(cmd_write_not_read_i),
    .cmd_addr_i          (cmd_addr_i),
    .cmd_yumi_o          (cmd_yumi_o),
    .cmd_done_i          (cmd_done_i),
    .v_o                 (v_o),
    .write_not_read_o    (write_not_read_o),
    .ch_addr_o           (ch_addr_o),
    .yumi_i              (yumi_i),
    .data_v_o            (data_v_o),
    .data_o              (data_o),
    .data_yumi_i         (data_yumi_i),
    .data_v_i            (data_v_i),
    .done_o              (done_o),
    .error_o             (error_o),
    .read_count_o        (read_count_o),
    .write_count_o       (write_count_o),
    .cycle_count_o       (cycle_count_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Trace and DRAM-responder state.
  logic          tr_w [8];
  logic [AW-1:0] tr_a [8];
  int tr_len, idx, cmd_dly, data_dly, vcnt, dcnt;
  int rd_acc, wr_acc, stall_bad, overlap, cyc, start_cyc, first_v;
  logic ret_pulse, ret_with_v;
  logic [AW-1:0] last_addr;
  logic [31:0] wq[$];

  task automatic clear_tb();
    tr_len = 0; idx = 0; cmd_dly = 0; data_dly = 0; vcnt = 0; dcnt = 0;
    rd_acc = 0; wr_acc = 0; stall_bad = 0; first_v = -1;
    ret_pulse = 1'b0; ret_with_v = 1'b0; last_addr = '0;
    wq.delete();
    start_i = 0; cmd_v_i = 0; cmd_write_not_read_i = 0; cmd_addr_i = '0;
    cmd_done_i = 0; yumi_i = 0; data_yumi_i = 0; data_v_i = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n_i = 1'b0;
    clear_tb();
    repeat (2) @(posedge clk);
    #1 reset_n_i = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called at posedge+1: present trace head and DRAM responses.
  task automatic drive();
    if (v_o) vcnt++; else vcnt = 0;
    if (data_v_o) dcnt++; else dcnt = 0;
    yumi_i      = v_o && (vcnt > cmd_dly);
    data_yumi_i = data_v_o && (dcnt > data_dly);
    cmd_v_i     = (idx < tr_len);
    cmd_done_i  = (idx >= tr_len);
    if (idx < tr_len) begin
      cmd_write_not_read_i = tr_w[idx];
      cmd_addr_i           = tr_a[idx];
    end else begin
      cmd_write_not_read_i = 1'b0;
      cmd_addr_i           = '0;
    end
    data_v_i = ret_pulse || (ret_with_v && v_o && !write_not_read_o);
  endtask

  // Observe handshakes mid-cycle, then advance to the next posedge+1.
  task automatic cycle();
    #1;
    if (int'(cmd_yumi_o) + int'(v_o) + int'(data_v_o) > 1) overlap++;
    if (cmd_yumi_o) idx++;
    if (v_o && first_v < 0) first_v = cyc;
    if (v_o && vcnt > 1 && ch_addr_o != last_addr) stall_bad++;
    last_addr = ch_addr_o;
    if (v_o && yumi_i) begin
      if (write_not_read_o) wr_acc++; else rd_acc++;
    end
    if (data_v_o && data_yumi_i) wq.push_back(data_o[31:0]);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      cycle();
    end
  endtask

  task automatic ret();
    ret_pulse = 1'b1;
    drive();
    cycle();
    ret_pulse = 1'b0;
    data_v_i  = 1'b0;
  endtask

  task automatic start();
    start_i = 1'b1;
    first_v = -1;
    drive();
    start_cyc = cyc;
    cycle();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit && !done_o; i++) run(1);
    check_eq(tag, done_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; overlap = 0;
    clear_tb();

    // Reset state.
    #12;
    check_eq("rst_done", done_o, 0);
    check_eq("rst_error", error_o, 0);
    check_eq("rst_v", v_o, 0);
    check_eq("rst_counts", {read_count_o, write_count_o} | 64'(cycle_count_o), 0);
    do_reset();

    // 1: four reads, two credits, returns withheld.
    tr_len = 4;
    for (int i = 0; i < 4; i++) begin
      tr_w[i] = 1'b0;
      tr_a[i] = AW'(32'h100 + i);
    end
    start();
    run(12);
    check_eq("t1_accepts", rd_acc, 2);
    check_eq("t1_pops", idx, 2);
    check_eq("t1_state_fetch", 64'(dut.state_q), 64'(StFetch));
    ret_pulse = 1'b1;
    drive();
    #1 check_eq("t1_no_same_cycle_pop", cmd_yumi_o, 0);
    cycle();
    ret_pulse = 1'b0;
    run(1);
    check_eq("t1_third_pop", idx, 3);
    run(4);
    check_eq("t1_third_accept", rd_acc, 3);
    ret();
    run(4);
    check_eq("t1_fourth_accept", rd_acc, 4);
    run(3);
    check_eq("t1_drain", 64'(dut.state_q), 64'(StDrain));
    ret();
    ret();
    run(2);
    check_eq("t1_done", done_o, 1);
    check_eq("t1_read_count", read_count_o, 4);
    check_eq("t1_error", error_o, 0);

    // 2: three writes, handshakes delayed two cycles.
    do_reset();
    tr_len = 3;
    tr_w[0] = 1'b1; tr_a[0] = AW'(32'h10);
    tr_w[1] = 1'b1; tr_a[1] = AW'(32'h20);
    tr_w[2] = 1'b1; tr_a[2] = AW'(32'h30);
    cmd_dly = 2; data_dly = 2;
    start();
    wait_done("t2_done", 60);
    check_eq("t2_start_latency", first_v - start_cyc, 2);
    check_eq("t2_wdata_n", wq.size(), 3);
    if (wq.size() == 3) begin
      check_eq("t2_wdata0", wq[0], 32'h10);
      check_eq("t2_wdata1", wq[1], 32'h20);
      check_eq("t2_wdata2", wq[2], 32'h30);
    end
    check_eq("t2_write_count", write_count_o, 3);
    check_eq("t2_read_count", read_count_o, 0);
    check_eq("t2_addr_stable", stall_bad, 0);
    check_eq("t2_cycle_count", cycle_count_o, 23);

    // 3: W R W R, trace ends with two reads outstanding.
    do_reset();
    tr_len = 4;
    tr_w[0] = 1'b1; tr_a[0] = AW'(32'h40);
    tr_w[1] = 1'b0; tr_a[1] = AW'(32'h50);
    tr_w[2] = 1'b1; tr_a[2] = AW'(32'h60);
    tr_w[3] = 1'b0; tr_a[3] = AW'(32'h70);
    start();
    run(12);
    check_eq("t3_drain", 64'(dut.state_q), 64'(StDrain));
    check_eq("t3_outstanding", 64'(dut.credit_count), 2);
    ret();
    run(3);
    check_eq("t3_still_drain", 64'(dut.state_q), 64'(StDrain));
    check_eq("t3_not_done", done_o, 0);
    ret();
    check_eq("t3_done_next", done_o, 1);
    check_eq("t3_counts", {read_count_o, write_count_o}, {32'd2, 32'd2});
    if (wq.size() == 2) check_eq("t3_wdata1", wq[1], 32'h60);
    else check_eq("t3_wdata_n", wq.size(), 2);
    check_eq("t3_error", error_o, 0);

    // 4: protocol errors in IDLE.
    do_reset();
    ret();
    check_eq("t4_underflow_err", error_o, 1);
    check_eq("t4_outstanding", 64'(dut.credit_count), 0);
    do_reset();
    yumi_i = 1'b1;
    cycle();
    yumi_i = 1'b0;
    check_eq("t4_stray_yumi_err", error_o, 1);
    do_reset();
    data_yumi_i = 1'b1;
    cycle();
    data_yumi_i = 1'b0;
    check_eq("t4_stray_dyumi_err", error_o, 1);

    // 5: read accept and return in the same cycle at outstanding 1.
    do_reset();
    tr_len = 2;
    tr_w[0] = 1'b0; tr_a[0] = AW'(32'h200);
    tr_w[1] = 1'b0; tr_a[1] = AW'(32'h204);
    start();
    for (int i = 0; i < 10 && rd_acc < 1; i++) run(1);
    ret_with_v = 1'b1;
    for (int i = 0; i < 10 && rd_acc < 2; i++) run(1);
    ret_with_v = 1'b0;
    data_v_i = 1'b0;
    check_eq("t5_outstanding", 64'(dut.credit_count), 1);
    check_eq("t5_error", error_o, 0);
    run(3);
    ret();
    run(1);
    check_eq("t5_done", done_o, 1);
    check_eq("t5_read_count", read_count_o, 2);

    // 6: async reset while stalled in WDATA, then a fresh run.
    do_reset();
    tr_len = 2;
    tr_w[0] = 1'b0; tr_a[0] = AW'(32'h70);
    tr_w[1] = 1'b1; tr_a[1] = AW'(32'h80);
    data_dly = 50;
    start();
    for (int i = 0; i < 20 && !data_v_o; i++) run(1);
    check_eq("t6_in_wdata", data_v_o, 1);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("t6_rst_valids", {cmd_yumi_o, v_o, data_v_o, done_o, error_o}, 0);
    check_eq("t6_rst_data", data_o | 64'(ch_addr_o) | 64'(write_not_read_o), 0);
    check_eq("t6_rst_counts", {read_count_o, write_count_o} | 64'(cycle_count_o), 0);
    clear_tb();
    data_v_i = 1'b1;  // late return of the in-flight read, absorbed by reset
    @(posedge clk); #1;
    data_v_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n_i = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_post_rst_error", error_o, 0);
    tr_len = 1;
    tr_w[0] = 1'b1; tr_a[0] = AW'(32'hA0);
    start();
    wait_done("t6_done", 30);
    check_eq("t6_counts", {read_count_o, write_count_o}, {32'd0, 32'd1});
    check_eq("t6_cycle_count", cycle_count_o, 5);
    if (wq.size() == 1) check_eq("t6_wdata", wq[0], 32'hA0);
    else check_eq("t6_wdata_n", wq.size(), 1);
    check_eq("t6_error", error_o, 0);

    check_eq("valids_exclusive", overlap, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
